// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with registered, read-before-write output.
// The read register only updates on an enabled access, so it holds between accesses.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Registered read of the pre-write word; cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's M-stage port: fixed wait-state FSM in front of a
// word-addressed RAM. Stall is held until the DONE cycle, in which load data is valid.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag and suppress out-of-range accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_stall,
    output logic        o_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req;
    logic              commit;   // high in the cycle whose closing edge enters DONE
    logic              oob;
    logic              ram_we;
    logic [AW-1:0]     idx;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr;

    assign req = i_read_en | i_write_en;
    assign idx = i_addr[AW+1:2];

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: count down the wait states, abort if the request disappears.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES != 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_stall = req & (state_q != DONE);
    assign ram_we  = commit & i_write_en & ~oob;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (commit),
        .we    (ram_we),
        .idx   (idx),
        .wdata (i_write_data),
        .rdata (ram_rdata)
    );

`ifdef DMEM_BOUNDS_CHECK_EN
    logic err_q;
    logic zero_q;   // last completed access was out of range: present zero data

    assign oob = (i_addr >> (AW + 2)) != '0;

    // Error pulse for the DONE cycle and sticky zero-data flag until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            err_q <= commit & oob;
            if (commit) begin
                zero_q <= oob;
            end
        end
    end

    assign o_err       = err_q;
    assign o_read_data = zero_q ? '0 : ram_rdata;
    assign unused_addr = ^i_addr[1:0];
`else
    // Upper address bits are ignored: accesses wrap modulo DEPTH_WORDS.
    assign oob         = 1'b0;
    assign o_err       = 1'b0;
    assign o_read_data = ram_rdata;
    assign unused_addr = ^{i_addr[1:0], i_addr >> (AW + 2)};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states), a per-cycle comparison against
// a cycle-count model of each, and literal checks for the directed scenarios.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int          AWB   = $clog2(DEPTH);
    localparam int          W0    = 2;
    localparam int          W1    = 0;

    logic        clk;
    logic        rst;
    logic        re   [2];
    logic        we   [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rd   [2];
    logic        st   [2];
    logic        er   [2];

    int n_tests;
    int n_fail;
    bit started;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u_dut_w2 (
        .clk(clk), .rst(rst), .i_read_en(re[0]), .i_write_en(we[0]), .i_addr(addr[0]),
        .i_write_data(wd[0]), .o_read_data(rd[0]), .o_stall(st[0]), .o_err(er[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut_w0 (
        .clk(clk), .rst(rst), .i_read_en(re[1]), .i_write_en(we[1]), .i_addr(addr[1]),
        .i_write_data(wd[1]), .o_read_data(rd[1]), .o_stall(st[1]), .o_err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // An access completes once the request has been seen for (wait+1) consecutive cycles;
    // the following cycle is the completion cycle, after which the responder is free again.
    logic [31:0] mm      [2][DEPTH];
    bit          mv      [2][DEPTH];
    int          elapsed [2];
    bit          in_done [2];
    logic [31:0] exp_data[2];
    bit          exp_known[2];
    logic        exp_err [2];

    function automatic int wof(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                elapsed[k]   = 0;
                in_done[k]   = 0;
                exp_data[k]  = '0;
                exp_known[k] = 1;
                exp_err[k]   = 1'b0;
            end else begin
                exp_err[k] = 1'b0;
                if (in_done[k]) begin
                    in_done[k] = 0;
                    elapsed[k] = 0;
                end else if (re[k] || we[k]) begin
                    elapsed[k]++;
                    if (elapsed[k] == wof(k) + 1) begin
                        int  i;
                        bit  oob;
                        i   = int'((addr[k] >> 2) % DEPTH);
                        oob = (addr[k] >> (AWB + 2)) != 0;
`ifdef DMEM_BOUNDS_CHECK_EN
`else
                        oob = 0;
`endif
                        if (oob) begin
                            exp_data[k]  = '0;
                            exp_known[k] = 1;
                            exp_err[k]   = 1'b1;
                        end else begin
                            exp_data[k]  = mm[k][i];
                            exp_known[k] = mv[k][i];
                            if (we[k]) begin
                                mm[k][i] = wd[k];
                                mv[k][i] = 1;
                            end
                        end
                        in_done[k] = 1;
                        elapsed[k] = 0;
                    end
                end else begin
                    elapsed[k] = 0;
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (started && !rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cyc_stall%0d", k), 32'(st[k]),
                    32'((re[k] || we[k]) && !in_done[k]));
                if (exp_known[k]) chk($sformatf("cyc_data%0d", k), rd[k], exp_data[k]);
                chk($sformatf("cyc_err%0d", k), 32'(er[k]), 32'(exp_err[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Present a request and hold it; returns at the negedge of the DONE cycle.
    task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, output int stalls);
        bit done;
        @(posedge clk);
        #1;
        re[k] = r; we[k] = w; addr[k] = a; wd[k] = d;
        stalls = 0;
        done   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!st[k]) begin
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) chk("access_timeout", 32'(stalls), 32'(wof(k) + 1));
    endtask

    task automatic drop(input int k);
        @(posedge clk);
        #1;
        re[k] = 0; we[k] = 0;
    endtask

    initial begin
        int s;
        n_tests = 0;
        n_fail  = 0;
        started = 0;
        rst     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            re[k] = 0; we[k] = 0; addr[k] = '0; wd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        started = 1;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_data", rd[0], 32'h0);
        chk("reset_stall", 32'(st[0]), 32'h0);
        chk("reset_err", 32'(er[0]), 32'h0);

        // 1: store then load with two wait states
        access(0, 0, 1, 32'h40, 32'hDEADBEEF, s);
        chk("t1_store_stalls", 32'(s), 32'd3);
        access(0, 1, 0, 32'h40, 32'h0, s);
        chk("t1_load_stalls", 32'(s), 32'd3);
        chk("t1_load_data", rd[0], 32'hDEADBEEF);
        drop(0);

        // 2: zero wait states, back-to-back stores then loads
        for (int i = 0; i < 4; i++) begin
            access(1, 0, 1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), s);
            chk("t2_store_stalls", 32'(s), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            access(1, 1, 0, 32'h100 + 32'(4 * i), 32'h0, s);
            chk("t2_load_stalls", 32'(s), 32'd1);
            chk("t2_load_data", rd[1], 32'hA0 + 32'(i));
        end
        drop(1);

        // 3: read+write together returns the old word
        access(0, 0, 1, 32'h10, 32'h1111, s);
        access(0, 1, 1, 32'h10, 32'h2222, s);
        chk("t3_rmw_old", rd[0], 32'h1111);
        access(0, 1, 0, 32'h10, 32'h0, s);
        chk("t3_new", rd[0], 32'h2222);
        drop(0);

        // 4: reset in the middle of a store
        access(0, 0, 1, 32'h20, 32'hA5A5A5A5, s);
        drop(0);
        @(posedge clk);
        #1;
        re[0] = 0; we[0] = 1; addr[0] = 32'h20; wd[0] = 32'h5555;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        re[0] = 0; we[0] = 0;
        #1;
        chk("t4_rst_data", rd[0], 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_stall", 32'(st[0]), 32'h0);
        access(0, 1, 0, 32'h20, 32'h0, s);
        chk("t4_mem_kept", rd[0], 32'hA5A5A5A5);
        drop(0);

        // 5: request dropped during WAIT
        access(0, 1, 0, 32'h40, 32'h0, s);
        drop(0);
        @(posedge clk);
        #1;
        we[0] = 1; addr[0] = 32'h40; wd[0] = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        drop(0);
        @(negedge clk);
        chk("t5_abort_stall", 32'(st[0]), 32'h0);
        chk("t5_abort_data", rd[0], 32'hDEADBEEF);
        access(0, 1, 0, 32'h40, 32'h0, s);
        chk("t5_no_write", rd[0], 32'hDEADBEEF);
        drop(0);

        // 6: out-of-range address
        access(0, 0, 1, 32'h0, 32'hCAFEF00D, s);
        access(0, 1, 0, 32'h1000, 32'h0, s);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("t6_oob_data", rd[0], 32'h0);
        chk("t6_oob_err", 32'(er[0]), 32'h1);
        drop(0);
        @(negedge clk);
        chk("t6_err_pulse", 32'(er[0]), 32'h0);
        chk("t6_data_held", rd[0], 32'h0);
`else
        chk("t6_wrap_data", rd[0], 32'hCAFEF00D);
        chk("t6_no_err", 32'(er[0]), 32'h0);
        drop(0);
        @(negedge clk);
        chk("t6_data_held", rd[0], 32'hCAFEF00D);
`endif
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
